// File: rtl/nibbler_io_pkg.sv
// Shared constants for the nibbler processor I/O conditioning blocks.
package nibbler_io_pkg;
    localparam int NUM_BUTTONS             = 4;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000;
endpackage

// File: rtl/debounce_channel.sv
// One pushbutton channel: 2-FF synchroniser, stability counter, debounced level,
// registered press/release pulses and a sticky press flag.
module debounce_channel
    import nibbler_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    input  logic clear,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic press_flag
);

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                 sync1;
    logic                 sync2;
    logic [CNT_WIDTH-1:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1         <= 1'b0;
            sync2         <= 1'b0;
            cnt           <= '0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            press_flag    <= 1'b0;
        end else begin
            sync1         <= raw;
            sync2         <= sync1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            // Any return to the current level throws away the partial count.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                level         <= sync2;
                cnt           <= '0;
                press_pulse   <= sync2;
                release_pulse <= ~sync2;
            end else begin
                cnt <= cnt + CNT_WIDTH'(1);
            end
            // A press landing on the same edge as a clear must survive.
            press_flag <= press_pulse | (press_flag & ~clear);
        end
    end

endmodule

// File: rtl/button_debouncer.sv
// Conditions the four raw pushbuttons into clean levels, edge pulses and sticky
// press flags for the processor's pushbuttons input port.
module button_debouncer
    import nibbler_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] raw_buttons,
    input  logic [NUM_BUTTONS-1:0] clear_flags,
    output logic [NUM_BUTTONS-1:0] btn_level,
    output logic [NUM_BUTTONS-1:0] press_pulse,
    output logic [NUM_BUTTONS-1:0] release_pulse,
    output logic [NUM_BUTTONS-1:0] press_flags
);

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_WIDTH       (CNT_WIDTH)
        ) u_chan (
            .clock         (clock),
            .reset         (reset),
            .raw           (raw_buttons[i]),
            .clear         (clear_flags[i]),
            .level         (btn_level[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i]),
            .press_flag    (press_flags[i])
        );
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer with DEBOUNCE_CYCLES=4: directed vector table,
// hand-written corner sequences and random stimulus against a window-based model.
module tb_button_debouncer;

    localparam int N = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] raw_buttons = 4'h0;
    logic [3:0] clear_flags = 4'h0;
    logic [3:0] btn_level, press_pulse, release_pulse, press_flags;

    button_debouncer #(.DEBOUNCE_CYCLES(N)) dut (
        .clock         (clock),
        .reset         (reset),
        .raw_buttons   (raw_buttons),
        .clear_flags   (clear_flags),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .press_flags   (press_flags)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: level flips once the last N synchronised samples all disagree.
    logic [3:0] q_raw[$];
    logic [3:0] s2q[$];
    logic [3:0] m_level = 4'h0, m_pp = 4'h0, m_rp = 4'h0, m_pf = 4'h0;

    // Event bookkeeping for the directed sequences
    int ecnt;
    int press_at[4], rel_at[4], npress[4], nrel[4];

    typedef struct {
        logic       rst;
        logic [3:0] raw;
        logic [3:0] clr;
        logic [3:0] lvl;
        logic [3:0] pp;
        logic [3:0] rp;
        logic [3:0] pf;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_raw = {4'h0, 4'h0};
        s2q.delete();
        m_level = 4'h0; m_pp = 4'h0; m_rp = 4'h0; m_pf = 4'h0;
    endtask

    task automatic model_edge(input logic [3:0] raw, input logic [3:0] clr);
        logic [3:0] s2;
        logic [3:0] flip;
        s2 = q_raw[q_raw.size() - 2];
        q_raw.push_back(raw);
        if (q_raw.size() > 2) void'(q_raw.pop_front());
        s2q.push_back(s2);
        if (s2q.size() > N) void'(s2q.pop_front());
        m_pf = m_pp | (m_pf & ~clr);
        for (int i = 0; i < 4; i++) begin
            flip[i] = (s2q.size() == N);
            foreach (s2q[j]) if (s2q[j][i] == m_level[i]) flip[i] = 1'b0;
        end
        m_pp    = flip & ~m_level;
        m_rp    = flip & m_level;
        m_level = m_level ^ flip;
    endtask

    task automatic mark();
        ecnt = 0;
        for (int i = 0; i < 4; i++) begin
            press_at[i] = -1; rel_at[i] = -1; npress[i] = 0; nrel[i] = 0;
        end
    endtask

    task automatic step(input logic rst, input logic [3:0] raw, input logic [3:0] clr);
        reset       = rst;
        raw_buttons = raw;
        clear_flags = clr;
        ecnt++;
        @(posedge clock);
        if (!rst) model_reset();
        else      model_edge(raw, clr);
        #1;
        chk("model", {btn_level, press_pulse, release_pulse, press_flags},
            {m_level, m_pp, m_rp, m_pf});
        for (int i = 0; i < 4; i++) begin
            if (press_pulse[i]) begin
                if (npress[i] == 0) press_at[i] = ecnt;
                npress[i]++;
            end
            if (release_pulse[i]) begin
                if (nrel[i] == 0) rel_at[i] = ecnt;
                nrel[i]++;
            end
        end
        #3;
    endtask

    task automatic add(input logic rst, input logic [3:0] raw, input logic [3:0] clr,
                       input logic [3:0] lvl, input logic [3:0] pp, input logic [3:0] rp,
                       input logic [3:0] pf, input int reps);
        vec_t v;
        v = '{rst, raw, clr, lvl, pp, rp, pf};
        for (int r = 0; r < reps; r++) vecs.push_back(v);
    endtask

    task automatic settle();
        repeat (8) step(1'b1, 4'h0, 4'h0);
        step(1'b1, 4'h0, 4'hF);
    endtask

    initial begin
        logic [3:0] rnd_raw;
        logic [3:0] rclr;
        logic       rrst;
        model_reset();
        mark();

        // Reset with all buttons held, release, then let go of everything.
        add(0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 2);
        add(1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 5);
        add(1, 4'hF, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 1);
        add(1, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 1);
        add(1, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 5);
        add(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 1);
        add(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 1);
        add(1, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1);
        add(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1);
        foreach (vecs[k]) begin
            step(vecs[k].rst, vecs[k].raw, vecs[k].clr);
            chk($sformatf("vec%0d", k), {btn_level, press_pulse, release_pulse, press_flags},
                {vecs[k].lvl, vecs[k].pp, vecs[k].rp, vecs[k].pf});
        end

        // Clean press and release on bit 0
        settle(); mark();
        repeat (10) step(1'b1, 4'h1, 4'h0);
        chk("s2_press_at", press_at[0], 6);
        chk("s2_npress", npress[0], 1);
        mark();
        repeat (10) step(1'b1, 4'h0, 4'h0);
        chk("s2_rel_at", rel_at[0], 6);
        chk("s2_nrel", nrel[0], 1);

        // Bounce on bit 2: high 3, low 1, then steady high from edge 5
        settle(); mark();
        repeat (3) step(1'b1, 4'h4, 4'h0);
        step(1'b1, 4'h0, 4'h0);
        repeat (10) step(1'b1, 4'h4, 4'h0);
        chk("s3_press_at", press_at[2], 10);
        chk("s3_npress", npress[2], 1);

        // Sticky flag on bit 1, clear coinciding with a second press pulse
        settle(); mark();
        repeat (8) step(1'b1, 4'h2, 4'h0);
        chk("s4_flag_set", press_flags[1], 1);
        repeat (8) step(1'b1, 4'h0, 4'h0);
        step(1'b1, 4'h0, 4'h2);
        chk("s4_flag_clr", press_flags[1], 0);
        mark();
        repeat (6) step(1'b1, 4'h2, 4'h0);
        chk("s4_pulse", press_pulse[1], 1);
        step(1'b1, 4'h2, 4'h2);
        chk("s4_set_wins", press_flags[1], 1);
        step(1'b1, 4'h2, 4'h2);
        chk("s4_late_clr", press_flags[1], 0);

        // Bit 3 pressed while bit 0 bounces in runs of two
        settle(); mark();
        for (int e = 0; e < 12; e++) step(1'b1, {1'b1, 2'b00, ~e[1]}, 4'h0);
        chk("s5_b3_at", press_at[3], 6);
        chk("s5_b0_quiet", npress[0] + nrel[0], 0);

        // Reset two cycles into a bit-0 debounce
        settle(); mark();
        repeat (2) step(1'b1, 4'h1, 4'h0);
        step(1'b0, 4'h1, 4'h0);
        chk("s6_lvl", btn_level[0], 0);
        chk("s6_nopulse", npress[0], 0);
        mark();
        repeat (10) step(1'b1, 4'h1, 4'h0);
        chk("s6_press_at", press_at[0], 6);

        // Random bouncy stimulus with occasional clears and resets
        rnd_raw = 4'h0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 5) == 0) rnd_raw[i] = ~rnd_raw[i];
            rclr = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            rrst = ($urandom_range(0, 299) != 0);
            step(rrst, rnd_raw, rclr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Input-conditioning stage between the board's four raw pushbuttons and the processor's `pushbuttons[3:0]` input port. It synchronises each asynchronous button to `clock`, rejects contact bounce with a per-button stability counter, and presents clean levels to the processor's input buffer. It also produces one-cycle press/release pulses and sticky press flags, so software or a later interrupt stage can detect short presses it would otherwise miss between reads.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1000: consecutive cycles a synchronised input must differ from the current level before the level changes; legal range ≥1.
- `CNT_WIDTH`, default `$clog2(DEBOUNCE_CYCLES+1)`: width of each stability counter.

Ports:
- `clock`  in  1  single system clock, rising-edge.
- `reset`  in  1  asynchronous, active-low; all state cleared while low.
- `raw_buttons`  in  4  unsynchronised pushbutton levels, 1 = pressed.
- `clear_flags`  in  4  per-bit clear for `press_flags`, sampled on `clock`.
- `btn_level`  out  4  debounced levels; drives processor `pushbuttons`.
- `press_pulse`  out  4  one-cycle high on a 0→1 transition of `btn_level`.
- `release_pulse`  out  4  one-cycle high on a 1→0 transition of `btn_level`.
- `press_flags`  out  4  sticky per-button "pressed since last clear".

## Operation
- Four identical, independent channels, one per bit.
- Synchroniser: 2-FF chain `sync1 <= raw`, `sync2 <= sync1`. Only `sync2` feeds the debounce logic.
- Debounce, evaluated every edge:
  - `sync2 == level`: `cnt <= 0`.
  - `sync2 != level` and `cnt == DEBOUNCE_CYCLES-1`: `level <= sync2`, `cnt <= 0`.
  - Otherwise: `cnt <= cnt+1`.
- A bounce that returns `sync2` to `level` before the count completes resets `cnt`. Partial counts never carry over.
- Pulses are registered. A pulse asserts in the same cycle the new `level` first appears and is high for exactly one cycle.
- `press_flags[i]` is set by `press_pulse[i]` and cleared by `clear_flags[i]`. If set and clear occur in the same cycle, set wins, so no press is lost.
- `cnt` never exceeds `DEBOUNCE_CYCLES-1`, so there is no wrap-around. With `DEBOUNCE_CYCLES=1`, `level` follows `sync2` one cycle later.
- Reset values: `sync1`, `sync2`, `cnt`, `btn_level`, `press_pulse`, `release_pulse` and `press_flags` are all 0.
- Reset mid-count discards the count. After reset release, a button held down is reported pressed only after a full synchronise-and-debounce interval.

## Timing
- Raw change first sampled at edge k: `sync2` changes after edge k+1, and `btn_level`/pulse change after edge k+1+N (N = `DEBOUNCE_CYCLES`). Total latency is N+2 cycles.
- `press_flags` rises one cycle after `press_pulse`.
- `clear_flags` takes effect at the next edge.
- A glitch shorter than N consecutive synchronised cycles never changes `btn_level`.
- No combinational path exists from any input to any output.

## Structure
- Shared package `nibbler_io_pkg`:
  - `NUM_BUTTONS = 4`
  - default `DEBOUNCE_CYCLES`
- Sub-module `debounce_channel`: synchroniser, counter, level, pulse and flag for one bit. `button_debouncer` instantiates four copies and concatenates their outputs.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`.
1. Reset: hold `reset=0` with `raw_buttons=4'hF` → all outputs 0. Release reset with input held → `btn_level=4'hF` appears exactly 6 cycles later, with `press_pulse=4'hF` for one cycle.
2. Clean press and release on bit 0: `raw` 0→1 → `btn_level[0]` rises at cycle +6 with `press_pulse[0]`. `raw` 1→0 → `btn_level[0]` falls at cycle +6 with one-cycle `release_pulse[0]`.
3. Bounce on bit 2: toggle `raw` high for 3 cycles, low for 1, then high steady → `btn_level[2]` rises only 6 cycles after the final rising edge, with a single `press_pulse`.
4. Sticky flag on bit 1: press and release, then assert `clear_flags=4'h2` in the same cycle as a second `press_pulse[1]` → `press_flags[1]` stays 1. A clear one cycle later → 0.
5. Independence: bit 3 pressed while bit 0 bounces → bit 3 timing matches scenario 2 and bit 0 shows no pulse.
6. Reset mid-count: drop `reset` 2 cycles into a bit-0 debounce → `btn_level[0]=0` and no pulse. After release, a full 6-cycle interval is required.
